board_checker: RTL and testbench
================================

Name: board_checker

Overview:
- Reads back the board produced by the board generator and by the flood-fill logic.
- Scans every cell in raster order through a synchronous read port and compares each cell with the top-left cell, which holds the flood colour.
- Reports the win condition (all cells the same colour), the number of cells matching the flood colour, and whether any cell holds an out-of-range colour.
- Used after board generation and after every player move, using the same level start/ready handshake as the generator.

Parameters:
- MAX_SIZE, 26: largest board edge supported; the board array is MAX_SIZE x MAX_SIZE.
- COLOR_W, 3: width of one cell colour.
- CNT_W, 10: width of the match counter; must satisfy 2^CNT_W > MAX_SIZE^2.

Ports:
- CLOCK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CHECK_BOARD  in  1  level request to start a scan.
- final_SIZE  in  5  board edge length N; sampled at scan start.
- final_COLOR_NUM  in  4  number of legal colours C; sampled at scan start.
- RD_ROW  out  8  read address, row.
- RD_COL  out  8  read address, column.
- RD_COLOR  in  COLOR_W  cell data, valid exactly 1 cycle after the address is presented.
- CHECK_READY  out  1  results are valid.
- ALL_SAME  out  1  every cell equals cell (0,0).
- MATCH_COUNT  out  CNT_W  number of cells equal to cell (0,0), including (0,0).
- COLOR_ERR  out  1  some cell value is >= C, or N/C is illegal.

Behaviour:
- Reset values: RD_ROW=0, RD_COL=0, CHECK_READY=0, ALL_SAME=0, MATCH_COUNT=0, COLOR_ERR=0; state IDLE. Reset mid-scan aborts immediately, with no partial results.
- States:
  - IDLE -> REF when CHECK_BOARD=1 and CHECK_READY=0. N and C are latched. Address (0,0) is driven.
  - IDLE -> DONE instead when N=0, N>MAX_SIZE, C<3 or C>8. This sets COLOR_ERR=1, ALL_SAME=0, MATCH_COUNT=0.
  - REF (1 cycle): captures RD_COLOR as the reference colour. Sets count=1, same=1, and err=(ref>=C). Drives the address of the next cell.
  - REF -> DONE when N=1 (results: count 1, ALL_SAME=1).
  - SCAN: presents one new address per cycle in raster order. Column increments first; at column N-1 it wraps to 0 and the row increments.
  - SCAN compares the data returned for the address presented one cycle earlier:
    - equal: count+1;
    - not equal: same=0;
    - value >= C: err=1.
  - SCAN -> FLUSH after presenting address (N-1, N-1).
  - FLUSH (1 cycle): compares the last returned cell, then -> DONE.
  - DONE: CHECK_READY=1 and results are driven. Results hold stable while CHECK_BOARD=1.
  - DONE -> IDLE when CHECK_BOARD=0. CHECK_READY falls in that same cycle; results keep their values until the next scan starts.
- Latency: for N>=2, CHECK_READY rises N*N+2 cycles after the cycle in which CHECK_BOARD is sampled high.
- Address pipeline: exactly one read per cell and no cell skipped. RD_ROW/RD_COL stay < N at all times.
- Counter width: the count saturates at 2^CNT_W-1, which cannot occur with legal parameters.
- Input stability: CHECK_BOARD falling mid-scan is ignored; the scan completes, and because CHECK_BOARD is low when DONE is reached, the block returns to IDLE on the next cycle. N and C changing mid-scan have no effect.

Optional Feature:
- Macro: CHECK_EARLY_EXIT_EN.
- Defined: the first mismatch or out-of-range value ends the scan. The block goes through FLUSH to DONE, discarding any read already in flight. ALL_SAME=0 and MATCH_COUNT holds the matches counted before the mismatch.
- Not defined: a full scan always runs and latency is fixed at N*N+2.

Decomposition:
- Shared package board_pkg holds:
  - the MAX_SIZE, COLOR_W and CNT_W constants;
  - the state encoding for IDLE/REF/SCAN/FLUSH/DONE;
  - the min/max colour-count constants 3 and 8, shared with the generator.
- One sub-module, board_raster_counter: a row/column counter with load-zero, enable and size inputs, and a last-cell flag output.

Test Plan:
- Board N=4 all colour 2, C=3 -> CHECK_READY after 18 cycles; ALL_SAME=1, MATCH_COUNT=16, COLOR_ERR=0.
- N=5 with (0,0)=1, cells (2,3) and (4,4)=0, rest 1, C=4 -> ALL_SAME=0, MATCH_COUNT=23, COLOR_ERR=0; the read sequence covers all 25 addresses in raster order, none >= 5.
- N=3, C=3, cell (1,1)=5 -> COLOR_ERR=1, ALL_SAME=0, MATCH_COUNT=8.
- N=0 request, then separately N=27 request -> CHECK_READY on the next cycle with COLOR_ERR=1 and MATCH_COUNT=0; N=1 -> ALL_SAME=1, MATCH_COUNT=1.
- Hold CHECK_BOARD high after done -> results stable, no rescan; drop it, raise again -> new scan starts and CHECK_READY goes 0 then 1.
- Assert RESET at scan cycle 7 of N=6 -> all outputs 0 immediately; a new request then gives correct results. With CHECK_EARLY_EXIT_EN, a mismatch at cell index 3 -> done after 6 cycles with MATCH_COUNT=3.

Source files
------------

// File: rtl/board_pkg.sv
// Shared constants, state encoding and parameter check for the board logic.
// Used by board_checker and board_raster_counter.
package board_pkg;

    localparam int MAX_SIZE = 26;
    localparam int COLOR_W  = 3;
    localparam int CNT_W    = 10;

    localparam logic [4:0] MAX_N = 5'(MAX_SIZE);
    localparam logic [3:0] MIN_C = 4'd3;
    localparam logic [3:0] MAX_C = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REF,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic logic params_ok(
        input logic [4:0] n,
        input logic [3:0] c
    );
        return (n != 5'd0) && (n <= MAX_N) &&
               (c >= MIN_C) && (c <= MAX_C);
    endfunction

endpackage

// File: rtl/board_raster_counter.sv
// Row/column raster address counter; holds at the last cell of an
// N x N board so the address never leaves the board.
module board_raster_counter
    import board_pkg::*;
(
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       clear,
    input  logic       en,
    input  logic [4:0] size,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       last
);

    logic [7:0] edge_m1;

    assign edge_m1 = {3'b000, size} - 8'd1;
    assign last    = (row == edge_m1) && (col == edge_m1);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (en && !last) begin
            if (col == edge_m1) begin
                col <= '0;
                row <= row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/board_checker.sv
// Raster scan of the board comparing every cell with the flood colour at (0,0).
// Define CHECK_EARLY_EXIT_EN to stop at the first mismatch or bad colour.
module board_checker
    import board_pkg::*;
(
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               CHECK_BOARD,
    input  logic [4:0]         final_SIZE,
    input  logic [3:0]         final_COLOR_NUM,
    output logic [7:0]         RD_ROW,
    output logic [7:0]         RD_COL,
    input  logic [COLOR_W-1:0] RD_COLOR,
    output logic               CHECK_READY,
    output logic               ALL_SAME,
    output logic [CNT_W-1:0]   MATCH_COUNT,
    output logic               COLOR_ERR
);

    state_t             state;
    logic [4:0]         n_q;
    logic [3:0]         c_q;
    logic [COLOR_W-1:0] ref_q;
    logic [CNT_W-1:0]   cnt;
    logic               same;
    logic               err;
    logic               tail;

    logic       cnt_clear;
    logic       cnt_en;
    logic [4:0] cnt_size;
    logic       last;
    logic       hit;
    logic       bad;
    logic       stop;

    assign cnt_clear = (state == ST_DONE) && !CHECK_BOARD;
    assign cnt_en    = ((state == ST_IDLE) && CHECK_BOARD &&
                        params_ok(final_SIZE, final_COLOR_NUM)) ||
                       (state == ST_REF) || (state == ST_SCAN);
    assign cnt_size  = (state == ST_IDLE) ? final_SIZE : n_q;

    assign hit = (RD_COLOR == ref_q);
    assign bad = ({1'b0, RD_COLOR} >= c_q);

`ifdef CHECK_EARLY_EXIT_EN
    assign stop = !hit || bad;
`else
    assign stop = 1'b0;
`endif

    board_raster_counter u_raster (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .clear (cnt_clear),
        .en    (cnt_en),
        .size  (cnt_size),
        .row   (RD_ROW),
        .col   (RD_COL),
        .last  (last)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            n_q         <= '0;
            c_q         <= '0;
            ref_q       <= '0;
            cnt         <= '0;
            same        <= 1'b0;
            err         <= 1'b0;
            tail        <= 1'b0;
            CHECK_READY <= 1'b0;
            ALL_SAME    <= 1'b0;
            MATCH_COUNT <= '0;
            COLOR_ERR   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (CHECK_BOARD) begin
                        n_q <= final_SIZE;
                        c_q <= final_COLOR_NUM;
                        if (params_ok(final_SIZE, final_COLOR_NUM)) begin
                            state <= ST_REF;
                        end else begin
                            state       <= ST_DONE;
                            CHECK_READY <= 1'b1;
                            ALL_SAME    <= 1'b0;
                            MATCH_COUNT <= '0;
                            COLOR_ERR   <= 1'b1;
                        end
                    end
                end
                ST_REF: begin
                    ref_q <= RD_COLOR;
                    cnt   <= CNT_W'(1);
                    same  <= 1'b1;
                    err   <= bad;
                    tail  <= 1'b0;
                    if (n_q == 5'd1) begin
                        state       <= ST_DONE;
                        CHECK_READY <= 1'b1;
                        ALL_SAME    <= 1'b1;
                        MATCH_COUNT <= CNT_W'(1);
                        COLOR_ERR   <= bad;
`ifdef CHECK_EARLY_EXIT_EN
                    end else if (bad) begin
                        state <= ST_FLUSH;
`endif
                    end else begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // RD_COLOR belongs to the address presented last cycle
                    if (hit) begin
                        cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                    end else begin
                        same <= 1'b0;
                    end
                    if (bad) begin
                        err <= 1'b1;
                    end
                    if (tail || stop) begin
                        state <= ST_FLUSH;
                    end else if (last) begin
                        tail <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state       <= ST_DONE;
                    CHECK_READY <= 1'b1;
                    ALL_SAME    <= same;
                    MATCH_COUNT <= cnt;
                    COLOR_ERR   <= err;
                end
                ST_DONE: begin
                    if (!CHECK_BOARD) begin
                        state       <= ST_IDLE;
                        CHECK_READY <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    CHECK_READY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_checker.sv
// Self-checking bench for board_checker: directed table, hand sequences
// and randomized boards against a cell-list reference model.
module tb_board_checker;
    import board_pkg::*;

    logic               CLOCK = 1'b0;
    logic               RESET = 1'b1;
    logic               CHECK_BOARD = 1'b0;
    logic [4:0]         final_SIZE = '0;
    logic [3:0]         final_COLOR_NUM = '0;
    logic [7:0]         RD_ROW;
    logic [7:0]         RD_COL;
    logic [COLOR_W-1:0] RD_COLOR;
    logic               CHECK_READY;
    logic               ALL_SAME;
    logic [CNT_W-1:0]   MATCH_COUNT;
    logic               COLOR_ERR;

    int checks = 0;
    int errors = 0;

    logic [2:0] mem [0:31][0:31];

    board_checker dut (
        .CLOCK           (CLOCK),
        .RESET           (RESET),
        .CHECK_BOARD     (CHECK_BOARD),
        .final_SIZE      (final_SIZE),
        .final_COLOR_NUM (final_COLOR_NUM),
        .RD_ROW          (RD_ROW),
        .RD_COL          (RD_COL),
        .RD_COLOR        (RD_COLOR),
        .CHECK_READY     (CHECK_READY),
        .ALL_SAME        (ALL_SAME),
        .MATCH_COUNT     (MATCH_COUNT),
        .COLOR_ERR       (COLOR_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    // synchronous-read board memory
    always_ff @(posedge CLOCK) begin
        RD_COLOR <= mem[RD_ROW[4:0]][RD_COL[4:0]];
    end

    typedef struct {
        int n;
        int c;
        int base;
        int r0, c0, v0;
        int r1, c1, v1;
        int same, cnt, err, lat;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int base);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                mem[r][c] = 3'(base);
    endtask

    function automatic bit legal(input int n, input int c);
        return n >= 1 && n <= 26 && c >= 3 && c <= 8;
    endfunction

    // Walks the cell list in raster order using the board rules.
    task automatic model(input int n, input int c, output int e_same,
                         output int e_cnt, output int e_err, output int e_lat);
        int refc;
        int v;
        if (!legal(n, c)) begin
            e_same = 0; e_cnt = 0; e_err = 1; e_lat = 1;
            return;
        end
        refc   = int'(mem[0][0]);
        e_same = 1; e_cnt = 0; e_err = 0;
        e_lat  = (n == 1) ? 2 : n * n + 2;
        for (int i = 0; i < n * n; i++) begin
            v = int'(mem[i / n][i % n]);
            if (v == refc) e_cnt++;
            else e_same = 0;
            if (v >= c) e_err = 1;
`ifdef CHECK_EARLY_EXIT_EN
            if ((v != refc || v >= c) && n > 1) begin
                e_lat = i + 3;
                break;
            end
`endif
        end
    endtask

    task automatic scan(input string tag, input int n, input int c,
                        input int drop_at, input int e_same, input int e_cnt,
                        input int e_err, input int e_lat);
        int  lat = 0;
        int  visits = 1;
        int  bad_addr = 0;
        int  pr = 0;
        int  pc = 0;
        int  nr, nc;
        bit  seen = 0;
        int  limit = n * n + 40;
        @(negedge CLOCK);
        final_SIZE      = 5'(n);
        final_COLOR_NUM = 4'(c);
        CHECK_BOARD     = 1'b1;
        for (int k = 1; k <= limit && !seen; k++) begin
            @(posedge CLOCK);
            #1;
            if (k == drop_at) CHECK_BOARD = 1'b0;
            if (legal(n, c)) begin
                if (int'(RD_ROW) >= n || int'(RD_COL) >= n) begin
                    bad_addr++;
                end else if (int'(RD_ROW) != pr || int'(RD_COL) != pc) begin
                    nr = (pc == n - 1) ? pr + 1 : pr;
                    nc = (pc == n - 1) ? 0 : pc + 1;
                    if (int'(RD_ROW) != nr || int'(RD_COL) != nc) bad_addr++;
                    visits++;
                    pr = int'(RD_ROW);
                    pc = int'(RD_COL);
                end
            end
            if (CHECK_READY) begin
                seen = 1;
                lat  = k;
            end
        end
        check({tag, " ready"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(e_lat));
        check({tag, " all_same"}, 64'(ALL_SAME), 64'(e_same));
        check({tag, " match_count"}, 64'(MATCH_COUNT), 64'(e_cnt));
        check({tag, " color_err"}, 64'(COLOR_ERR), 64'(e_err));
        if (legal(n, c)) begin
            check({tag, " addr_order"}, 64'(bad_addr), 64'd0);
`ifndef CHECK_EARLY_EXIT_EN
            check({tag, " reads"}, 64'(visits), 64'(n * n));
`endif
        end
        if (CHECK_BOARD) begin
            repeat (3) begin
                @(posedge CLOCK);
                #1;
                check({tag, " hold_ready"}, 64'(CHECK_READY), 64'd1);
                check({tag, " hold_count"}, 64'(MATCH_COUNT), 64'(e_cnt));
            end
            CHECK_BOARD = 1'b0;
        end
        @(posedge CLOCK);
        #1;
        check({tag, " ready_fall"}, 64'(CHECK_READY), 64'd0);
        check({tag, " keep_count"}, 64'(MATCH_COUNT), 64'(e_cnt));
    endtask

    initial begin
        int es, ec, ee, el;
        int n, c, refc, drop;
        vec_t v;

        vecs[0] = '{4, 3, 2, -1, 0, 0, -1, 0, 0, 1, 16, 0, 18};
`ifdef CHECK_EARLY_EXIT_EN
        vecs[1] = '{5, 4, 1, 2, 3, 0, 4, 4, 0, 0, 13, 0, 16};
        vecs[2] = '{3, 3, 0, 1, 1, 5, -1, 0, 0, 0, 4, 1, 7};
        vecs[8] = '{4, 4, 1, 0, 3, 2, -1, 0, 0, 0, 3, 0, 6};
`else
        vecs[1] = '{5, 4, 1, 2, 3, 0, 4, 4, 0, 0, 23, 0, 27};
        vecs[2] = '{3, 3, 0, 1, 1, 5, -1, 0, 0, 0, 8, 1, 11};
        vecs[8] = '{4, 4, 1, 0, 3, 2, -1, 0, 0, 0, 15, 0, 18};
`endif
        vecs[3] = '{0, 4, 1, -1, 0, 0, -1, 0, 0, 0, 0, 1, 1};
        vecs[4] = '{27, 4, 1, -1, 0, 0, -1, 0, 0, 0, 0, 1, 1};
        vecs[5] = '{1, 3, 2, -1, 0, 0, -1, 0, 0, 1, 1, 0, 2};
        vecs[6] = '{4, 2, 1, -1, 0, 0, -1, 0, 0, 0, 0, 1, 1};
        vecs[7] = '{4, 9, 1, -1, 0, 0, -1, 0, 0, 0, 0, 1, 1};
        vecs[9] = '{26, 8, 7, -1, 0, 0, -1, 0, 0, 1, 676, 0, 678};

        fill(0);
        repeat (2) @(posedge CLOCK);
        #1;
        check("reset ready", 64'(CHECK_READY), 64'd0);
        check("reset all_same", 64'(ALL_SAME), 64'd0);
        check("reset count", 64'(MATCH_COUNT), 64'd0);
        check("reset err", 64'(COLOR_ERR), 64'd0);
        check("reset row", 64'(RD_ROW), 64'd0);
        check("reset col", 64'(RD_COL), 64'd0);
        @(negedge CLOCK);
        RESET = 1'b0;

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            fill(v.base);
            if (v.r0 >= 0) mem[v.r0][v.c0] = 3'(v.v0);
            if (v.r1 >= 0) mem[v.r1][v.c1] = 3'(v.v1);
            scan($sformatf("vec%0d", i), v.n, v.c, 0,
                 v.same, v.cnt, v.err, v.lat);
        end

        // CHECK_BOARD dropped mid-scan: scan still completes
        fill(1);
        scan("drop_mid", 3, 3, 3, 1, 9, 0, 11);

        // reset in the middle of an N=6 scan
        fill(2);
        @(negedge CLOCK);
        final_SIZE      = 5'd6;
        final_COLOR_NUM = 4'd4;
        CHECK_BOARD     = 1'b1;
        repeat (7) @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        #1;
        check("midreset ready", 64'(CHECK_READY), 64'd0);
        check("midreset all_same", 64'(ALL_SAME), 64'd0);
        check("midreset count", 64'(MATCH_COUNT), 64'd0);
        check("midreset err", 64'(COLOR_ERR), 64'd0);
        check("midreset row", 64'(RD_ROW), 64'd0);
        check("midreset col", 64'(RD_COL), 64'd0);
        @(negedge CLOCK);
        CHECK_BOARD = 1'b0;
        RESET       = 1'b0;
        mem[3][4] = 3'd1;
        model(6, 4, es, ec, ee, el);
        scan("after_reset", 6, 4, 0, es, ec, ee, el);

        for (int it = 0; it < 25; it++) begin
            n    = $urandom_range(0, 9);
            c    = $urandom_range(2, 9);
            refc = $urandom_range(0, 7);
            fill($urandom_range(0, 7));
            for (int r = 0; r < n; r++)
                for (int q = 0; q < n; q++)
                    mem[r][q] = ($urandom_range(0, 9) < 7) ?
                                3'(refc) : 3'($urandom_range(0, 7));
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 0;
            model(n, c, es, ec, ee, el);
            scan($sformatf("rand%0d", it), n, c, drop, es, ec, ee, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
